// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase controller.
//   - phase_e   : 3-bit phase encoding, NS green through pedestrian walk
//   - dir_e     : which road gets green after a pedestrian walk
//   - LampR/Y/G : one-hot lamp codes, bit order {Red, Yellow, Green}
//   - MaxPhase  : largest legal phase length for the 7-bit timer
//   - lamp_decode / phase_len_ok helpers
package traffic_pkg;

  // Largest legal phase length. Anything above this is rejected at elaboration.
  localparam int unsigned MaxPhase = 124;

  // Width of the external phase-timer count.
  localparam int unsigned CntW = 7;

  typedef enum logic [2:0] {
    StNsGreen  = 3'd0,
    StNsYellow = 3'd1,
    StAllRedA  = 3'd2,
    StEwGreen  = 3'd3,
    StEwYellow = 3'd4,
    StAllRedB  = 3'd5,
    StPedWalk  = 3'd6
  } phase_e;

  typedef enum logic {
    DirNs = 1'b0,
    DirEw = 1'b1
  } dir_e;

  // One-hot lamp codes; MSB is Red, LSB is Green.
  localparam logic [2:0] LampR = 3'b100;
  localparam logic [2:0] LampY = 3'b010;
  localparam logic [2:0] LampG = 3'b001;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
  } lamps_t;

  // Lamp pattern for a phase. Every phase not listed keeps both roads red,
  // so an illegal state code can never show two non-red roads.
  function automatic lamps_t lamp_decode(phase_e phase);
    lamps_t lamps;
    lamps.ns   = LampR;
    lamps.ew   = LampR;
    lamps.walk = 1'b0;
    case (phase)
      StNsGreen:  lamps.ns   = LampG;
      StNsYellow: lamps.ns   = LampY;
      StEwGreen:  lamps.ew   = LampG;
      StEwYellow: lamps.ew   = LampY;
      StPedWalk:  lamps.walk = 1'b1;
      default:    ;
    endcase
    return lamps;
  endfunction

  function automatic bit phase_len_ok(int unsigned len);
    return (len >= 1) && (len <= MaxPhase);
  endfunction

endpackage

// File: rtl/ped_request_latch.sv
// Pedestrian request latch.
// Edge-detects the level request, holds a pending flag until the controller
// enters the walk phase, and pulses the acknowledge on the first walk cycle.
//   clk_i        : system clock, rising edge
//   clear_i      : synchronous active-high clear
//   ped_req_i    : pedestrian request level
//   enter_walk_i : controller is moving into the walk phase this cycle
//   pending_o    : a request is waiting to be served
//   ped_ack_o    : one-cycle acknowledge, high on the first walk cycle
module ped_request_latch (
  input  logic clk_i,
  input  logic clear_i,
  input  logic ped_req_i,
  input  logic enter_walk_i,
  output logic pending_o,
  output logic ped_ack_o
);

  logic ped_req_q, ped_req_d;
  logic pending_q, pending_d;
  logic ack_q, ack_d;
  logic req_rise;

  // Only a fresh rising edge counts, so a request held after its
  // acknowledge never triggers a second walk.
  assign req_rise = ped_req_i & ~ped_req_q;

  always_comb begin
    ped_req_d = ped_req_i;
    pending_d = pending_q;
    if (enter_walk_i) begin
      pending_d = 1'b0;
    end
    // A new edge on the serving cycle belongs to the next walk, so it wins.
    if (req_rise) begin
      pending_d = 1'b1;
    end
    ack_d = enter_walk_i;
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      ped_req_q <= 1'b0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      ped_req_q <= ped_req_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
    end
  end

  assign pending_o = pending_q;
  assign ped_ack_o = ack_q;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic-light phase controller with a pedestrian walk phase.
// Sequences NS green/yellow, all-red, EW green/yellow, all-red, and inserts
// a walk phase after an all-red when a pedestrian request is pending. Each
// phase is timed by an external 7-bit counter that this block clears and
// enables.
//   Clk      : system clock, rising edge
//   Clear    : synchronous active-high reset
//   Q        : timer count, Q[0] is the MSB
//   PedReq   : pedestrian request level, held until PedAck
//   CntClear : timer synchronous clear
//   CntCount : timer count enable
//   NS_Lamp  : NS one-hot {Red, Yellow, Green}
//   EW_Lamp  : EW one-hot {Red, Yellow, Green}
//   Walk     : pedestrian walk lamp
//   PedAck   : one-cycle request acknowledge
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_T  = 100,
  parameter int unsigned YELLOW_T = 20,
  parameter int unsigned ALLRED_T = 5,
  parameter int unsigned WALK_T   = 60
) (
  input  logic       Clk,
  input  logic       Clear,
  input  logic [0:6] Q,
  input  logic       PedReq,
  output logic       CntClear,
  output logic       CntCount,
  output logic [0:2] NS_Lamp,
  output logic [0:2] EW_Lamp,
  output logic       Walk,
  output logic       PedAck
);

  // Phase lengths must fit the 7-bit timer with headroom.
  if (!phase_len_ok(GREEN_T) || !phase_len_ok(YELLOW_T) ||
      !phase_len_ok(ALLRED_T) || !phase_len_ok(WALK_T)) begin : gen_bad_param
    $fatal(1, "traffic_phase_ctrl: phase lengths must be within 1..124");
  end

  // Last count value of each phase.
  localparam logic [CntW-1:0] GreenLast  = CntW'(GREEN_T - 1);
  localparam logic [CntW-1:0] YellowLast = CntW'(YELLOW_T - 1);
  localparam logic [CntW-1:0] AllRedLast = CntW'(ALLRED_T - 1);
  localparam logic [CntW-1:0] WalkLast   = CntW'(WALK_T - 1);

  phase_e          state_q, state_d;
  dir_e            next_dir_q, next_dir_d;
  lamps_t          lamps_q, lamps_d;
  logic [CntW-1:0] q_val;
  logic [CntW-1:0] phase_last;
  logic            terminal;
  logic            enter_walk;
  logic            pending;

  // Q is declared [0:6] with Q[0] as MSB, so a plain copy keeps the weight.
  assign q_val = Q;

  always_comb begin
    case (state_q)
      StNsGreen, StEwGreen:   phase_last = GreenLast;
      StNsYellow, StEwYellow: phase_last = YellowLast;
      StAllRedA, StAllRedB:   phase_last = AllRedLast;
      StPedWalk:              phase_last = WalkLast;
      default:                phase_last = '0;
    endcase
  end

  // Greater-or-equal so an overshooting count still ends the phase.
  assign terminal = (q_val >= phase_last);

  // The timer registers these, so Q reads zero on the first cycle of each phase.
  assign CntClear = Clear | terminal;
  assign CntCount = ~Clear & ~terminal;

  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
    enter_walk = 1'b0;
    if (terminal) begin
      case (state_q)
        StNsGreen:  state_d = StNsYellow;
        StNsYellow: state_d = StAllRedA;
        StAllRedA: begin
          next_dir_d = DirEw;
          if (pending) begin
            state_d    = StPedWalk;
            enter_walk = 1'b1;
          end else begin
            state_d = StEwGreen;
          end
        end
        StEwGreen:  state_d = StEwYellow;
        StEwYellow: state_d = StAllRedB;
        StAllRedB: begin
          next_dir_d = DirNs;
          if (pending) begin
            state_d    = StPedWalk;
            enter_walk = 1'b1;
          end else begin
            state_d = StNsGreen;
          end
        end
        StPedWalk:  state_d = (next_dir_q == DirEw) ? StEwGreen : StNsGreen;
        default:    state_d = StNsGreen;
      endcase
    end
    // Lamps are registered alongside the state so they decode the new phase.
    lamps_d = lamp_decode(state_d);
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      state_q    <= StNsGreen;
      next_dir_q <= DirEw;
      lamps_q    <= lamp_decode(StNsGreen);
    end else begin
      state_q    <= state_d;
      next_dir_q <= next_dir_d;
      lamps_q    <= lamps_d;
    end
  end

  ped_request_latch u_ped_request_latch (
    .clk_i        (Clk),
    .clear_i      (Clear),
    .ped_req_i    (PedReq),
    .enter_walk_i (enter_walk),
    .pending_o    (pending),
    .ped_ack_o    (PedAck)
  );

  assign NS_Lamp = lamps_q.ns;
  assign EW_Lamp = lamps_q.ew;
  assign Walk    = lamps_q.walk;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with a behavioural 7-bit phase
// timer behind it. Phase lengths: green 4, yellow 2, all-red 1, walk 3.
module tb_traffic_phase_ctrl;

  localparam int GreenT  = 4;
  localparam int YellowT = 2;
  localparam int AllRedT = 1;
  localparam int WalkT   = 3;

  localparam logic [0:2] R = 3'b100;
  localparam logic [0:2] Y = 3'b010;
  localparam logic [0:2] G = 3'b001;

  logic       clk;
  logic       clear;
  logic       ped_req;
  logic       cnt_clear;
  logic       cnt_count;
  logic [0:2] ns_lamp;
  logic [0:2] ew_lamp;
  logic       walk;
  logic       ped_ack;

  logic [6:0] timer_q;
  logic       force_en;
  logic [6:0] force_val;
  logic [0:6] q_bus;

  int n_asserts = 0;
  int n_fail    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External phase timer.
  always_ff @(posedge clk) begin
    if (cnt_clear) begin
      timer_q <= '0;
    end else if (cnt_count) begin
      timer_q <= timer_q + 7'd1;
    end
  end

  assign q_bus = force_en ? force_val : timer_q;

  traffic_phase_ctrl #(
    .GREEN_T  (GreenT),
    .YELLOW_T (YellowT),
    .ALLRED_T (AllRedT),
    .WALK_T   (WalkT)
  ) dut (
    .Clk      (clk),
    .Clear    (clear),
    .Q        (q_bus),
    .PedReq   (ped_req),
    .CntClear (cnt_clear),
    .CntCount (cnt_count),
    .NS_Lamp  (ns_lamp),
    .EW_Lamp  (ew_lamp),
    .Walk     (walk),
    .PedAck   (ped_ack)
  );

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks `count` cycles of one phase starting at count value `first`.
  // Returns just after the posedge that starts the following cycle.
  task automatic phase(input string tag, input logic [0:2] ns, input logic [0:2] ew,
                       input logic wlk, input logic ack, input int len,
                       input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d] ns", tag, i), 7'(ns_lamp), 7'(ns));
      chk($sformatf("%s[%0d] ew", tag, i), 7'(ew_lamp), 7'(ew));
      chk($sformatf("%s[%0d] walk", tag, i), 7'(walk), 7'(wlk));
      chk($sformatf("%s[%0d] ack", tag, i), 7'(ped_ack), 7'(ack && (i == 0)));
      chk($sformatf("%s[%0d] q", tag, i), 7'(q_bus), 7'(i));
      chk($sformatf("%s[%0d] cclr", tag, i), 7'(cnt_clear), 7'(i == len - 1));
      chk($sformatf("%s[%0d] ccnt", tag, i), 7'(cnt_count), 7'(i != len - 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic full_cycle(input string tag);
    phase({tag, " nsg"}, G, R, 1'b0, 1'b0, GreenT, 0, GreenT);
    phase({tag, " nsy"}, Y, R, 1'b0, 1'b0, YellowT, 0, YellowT);
    phase({tag, " ara"}, R, R, 1'b0, 1'b0, AllRedT, 0, AllRedT);
    phase({tag, " ewg"}, R, G, 1'b0, 1'b0, GreenT, 0, GreenT);
    phase({tag, " ewy"}, R, Y, 1'b0, 1'b0, YellowT, 0, YellowT);
    phase({tag, " arb"}, R, R, 1'b0, 1'b0, AllRedT, 0, AllRedT);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear     = 1'b1;
    ped_req   = 1'b0;
    force_en  = 1'b0;
    force_val = '0;

    // Reset state while Clear is held.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst cclr", 7'(cnt_clear), 7'd1);
    chk("rst ccnt", 7'(cnt_count), 7'd0);
    chk("rst ns", 7'(ns_lamp), 7'(G));
    chk("rst ew", 7'(ew_lamp), 7'(R));
    chk("rst walk", 7'(walk), 7'd0);
    chk("rst ack", 7'(ped_ack), 7'd0);
    chk("rst q", 7'(q_bus), 7'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;

    // Free run, no pedestrian.
    full_cycle("free0");
    full_cycle("free1");

    // Request rises in NS green cycle 1 and stays high.
    phase("p1 nsg", G, R, 1'b0, 1'b0, GreenT, 0, 1);
    ped_req = 1'b1;
    phase("p1 nsg", G, R, 1'b0, 1'b0, GreenT, 1, GreenT - 1);
    phase("p1 nsy", Y, R, 1'b0, 1'b0, YellowT, 0, YellowT);
    phase("p1 ara", R, R, 1'b0, 1'b0, AllRedT, 0, AllRedT);
    phase("p1 walk", R, R, 1'b1, 1'b1, WalkT, 0, WalkT);
    phase("p1 ewg", R, G, 1'b0, 1'b0, GreenT, 0, GreenT);
    phase("p1 ewy", R, Y, 1'b0, 1'b0, YellowT, 0, YellowT);
    phase("p1 arb", R, R, 1'b0, 1'b0, AllRedT, 0, AllRedT);

    // Request still held: no second walk.
    full_cycle("held");
    ped_req = 1'b0;

    // Rising edge lands on the ALLRED_B terminal cycle.
    phase("p2 nsg", G, R, 1'b0, 1'b0, GreenT, 0, GreenT);
    phase("p2 nsy", Y, R, 1'b0, 1'b0, YellowT, 0, YellowT);
    phase("p2 ara", R, R, 1'b0, 1'b0, AllRedT, 0, AllRedT);
    phase("p2 ewg", R, G, 1'b0, 1'b0, GreenT, 0, GreenT);
    phase("p2 ewy", R, Y, 1'b0, 1'b0, YellowT, 0, YellowT);
    ped_req = 1'b1;
    phase("p2 arb", R, R, 1'b0, 1'b0, AllRedT, 0, AllRedT);
    phase("p2b nsg", G, R, 1'b0, 1'b0, GreenT, 0, GreenT);
    phase("p2b nsy", Y, R, 1'b0, 1'b0, YellowT, 0, YellowT);
    phase("p2b ara", R, R, 1'b0, 1'b0, AllRedT, 0, AllRedT);
    phase("p2b walk", R, R, 1'b1, 1'b1, WalkT, 0, WalkT);
    ped_req = 1'b0;

    // New request in EW green, then Clear at Q=2 must drop it.
    phase("c ewg", R, G, 1'b0, 1'b0, GreenT, 0, 1);
    ped_req = 1'b1;
    phase("c ewg", R, G, 1'b0, 1'b0, GreenT, 1, 1);
    clear   = 1'b1;
    ped_req = 1'b0;
    @(negedge clk);
    chk("clr q", 7'(q_bus), 7'd2);
    chk("clr cclr", 7'(cnt_clear), 7'd1);
    chk("clr ccnt", 7'(cnt_count), 7'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    phase("c2 nsg", G, R, 1'b0, 1'b0, GreenT, 0, GreenT);

    // Overshoot: force Q=7 on the first NS yellow cycle.
    force_val = 7'd7;
    force_en  = 1'b1;
    @(negedge clk);
    chk("ovr ns", 7'(ns_lamp), 7'(Y));
    chk("ovr cclr", 7'(cnt_clear), 7'd1);
    chk("ovr ccnt", 7'(cnt_count), 7'd0);
    @(posedge clk);
    #1;
    force_en = 1'b0;
    // Pending was cleared by Clear, so no walk here.
    phase("ovr ara", R, R, 1'b0, 1'b0, AllRedT, 0, AllRedT);
    phase("ovr ewg", R, G, 1'b0, 1'b0, GreenT, 0, GreenT);
    phase("ovr ewy", R, Y, 1'b0, 1'b0, YellowT, 0, YellowT);
    phase("ovr arb", R, R, 1'b0, 1'b0, AllRedT, 0, AllRedT);
    phase("ovr nsg", G, R, 1'b0, 1'b0, GreenT, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
